// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Start bit (0) in bit 0, data LSB first, stop bit (1) in bit 9.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, with wrap.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         gnt
);

  localparam int IW = $clog2(N);

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    logic [IW:0]   s;
    logic [IW-1:0] p;
    s     = '0;
    p     = '0;
    valid = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int k = N; k >= 1; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      p = s[IW-1:0];
      if (req[p]) begin
        valid  = 1'b1;
        idx    = p;
        gnt    = '0;
        gnt[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
//
// state  | meaning
// IDLE   | no frame in flight; grant the next requester when any req is high
// LAUNCH | tx_rdy held, waiting for tx_confirm or launch timeout
// WAIT   | frame leaving the line plus guard time; no new launch
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int CLKS_PER_BIT   = 10417,
  parameter int FRAME_BITS     = 11,
  parameter int GUARD_CLKS     = 16,
  parameter int LAUNCH_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr,
  output logic [FRAME_W-1:0]       tx_frame,
  output logic                     tx_rdy,
  input  logic                     tx_confirm
);

  localparam int IW        = $clog2(N_REQ);
  localparam int WAIT_CLKS = FRAME_BITS * CLKS_PER_BIT + GUARD_CLKS;
  localparam int CW_FRAME  = $clog2(WAIT_CLKS);
  localparam int CW_LAUNCH = $clog2(LAUNCH_TIMEOUT + 1);
  // One counter serves both states, so it must fit the larger terminal count.
  localparam int CW        = (CW_FRAME > CW_LAUNCH) ? CW_FRAME : CW_LAUNCH;
  localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CLKS - 1);
  localparam logic [CW-1:0] LAUNCH_LAST = CW'(LAUNCH_TIMEOUT - 1);

  state_t               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        grant_id_q;
  logic [N_REQ-1:0]     ack_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 tx_rdy_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [CW-1:0]        cnt_q;

  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [N_REQ-1:0]     pick_gnt;
  logic [DATA_W-1:0]    pick_byte;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx),
    .gnt   (pick_gnt)
  );

  assign pick_byte = data[{pick_idx, 3'b000} +: DATA_W];

  // Sequencer: grant, launch handshake, frame hold-off; every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      grant_id_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_rdy_q   <= 1'b0;
      frame_q    <= '1;
      cnt_q      <= '0;
    end else begin
      ack_q <= '0;
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            frame_q    <= make_frame(pick_byte);
            grant_id_q <= pick_idx;
            ptr_q      <= pick_idx;
            ack_q      <= pick_gnt;
            tx_rdy_q   <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_confirm) begin
            tx_rdy_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= WAIT;
          end else if (cnt_q == LAUNCH_LAST) begin
            // Frame is dropped, not retried; the producer already saw its ack.
            tx_rdy_q <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          tx_rdy_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign tx_frame = frame_q;
  assign tx_rdy   = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        err_clr;
  logic        tx_confirm;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;
  logic [9:0]  tx_frame;
  logic        tx_rdy;

  logic        tx_auto;
  logic        tx_force;
  logic        prev_rdy;

  int n_cmp;
  int n_err;
  int n;

  uart_tx_arbiter #(
    .N_REQ          (4),
    .CLKS_PER_BIT   (4),
    .FRAME_BITS     (11),
    .GUARD_CLKS     (2),
    .LAUNCH_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .tx_frame   (tx_frame),
    .tx_rdy     (tx_rdy),
    .tx_confirm (tx_confirm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: sees tx_rdy one cycle after the grant, then pulses confirm for one cycle.
  initial begin
    tx_confirm = 1'b0;
    prev_rdy   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_confirm = tx_force || (tx_auto && tx_rdy && prev_rdy);
      prev_rdy   = tx_rdy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack == 4'b0000 && cnt < 200);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'b0000;
    err_clr  = 1'b0;
    tx_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    data     = 32'h0;
    tx_auto  = 1'b1;
    do_reset();

    // Reset values
    check("rst_ack",      ack,      4'b0000);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy",     busy,     1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_frame",    tx_frame, 10'h3FF);
    check("rst_tx_rdy",   tx_rdy,   1'b0);

    // Single byte 0xA5 from requester 0
    data[7:0] = 8'hA5;
    req = 4'b0001;
    wait_ack(n);
    req = 4'b0000;
    check("t1_grant_lat", n,        1);
    check("t1_ack",       ack,      4'b0001);
    check("t1_frame",     tx_frame, 10'h34A);
    check("t1_rdy0",      tx_rdy,   1'b1);
    check("t1_busy",      busy,     1'b1);
    tick();
    check("t1_ack_1cyc",  ack,      4'b0000);
    check("t1_rdy1",      tx_rdy,   1'b1);
    tick();
    check("t1_rdy_low",   tx_rdy,   1'b0);
    n = 0;
    do begin tick(); n++; end while (busy && n < 200);
    check("t1_wait_len",  n,        46);

    // All four requesting from reset, each drops on its ack
    do_reset();
    data = 32'h44332211;
    req  = 4'b1111;
    wait_ack(n);
    check("t2_first_lat", n, 1);
    for (int k = 0; k < 4; k++) begin
      check("t2_ack",      ack,      32'(1 << k));
      check("t2_grant_id", grant_id, k);
      check("t2_frame",    tx_frame, 32'h200 | (32'(data[8*k +: 8]) << 1));
      req[k] = 1'b0;
      if (k < 3) begin
        wait_ack(n);
        check("t2_spacing", n, 49);
      end
    end

    // Requesters 1 and 2 held continuously
    do_reset();
    data = 32'h77C35A11;
    req  = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      check("t3_ack",      ack,      (k % 2 == 0) ? 4'b0010 : 4'b0100);
      check("t3_grant_id", grant_id, (k % 2 == 0) ? 2'd1 : 2'd2);
      check("t3_frame",    tx_frame, (k % 2 == 0) ? 10'h2B4 : 10'h386);
    end
    req = 4'b0000;

    // Launch timeout, err_clr, and set-wins collision
    do_reset();
    tx_auto   = 1'b0;
    data[7:0] = 8'h3C;
    req       = 4'b0001;
    wait_ack(n);
    req = 4'b0000;
    check("t4_frame", tx_frame, 10'h278);
    n = 0;
    do begin tick(); n++; end while (tx_rdy && n < 50);
    check("t4_rdy_len",  n,    8);
    check("t4_err",      err,  1'b1);
    check("t4_busy",     busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_err_clr",  err,  1'b0);
    req = 4'b0001;
    wait_ack(n);
    req = 4'b0000;
    check("t4_regrant",  n,    1);
    repeat (7) tick();
    check("t4_err_pre",  err,    1'b0);
    check("t4_rdy_pre",  tx_rdy, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_set_wins", err,    1'b1);
    check("t4_rdy_drop", tx_rdy, 1'b0);

    // tx_confirm ignored while IDLE and during WAIT
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    tx_force = 1'b1;
    tick();
    tx_force = 1'b0;
    check("t5_idle_busy", busy,   1'b0);
    check("t5_idle_err",  err,    1'b0);
    check("t5_idle_rdy",  tx_rdy, 1'b0);
    tick();
    tx_auto   = 1'b1;
    data[7:0] = 8'hA5;
    req       = 4'b0001;
    wait_ack(n);
    req = 4'b0000;
    tick();
    tick();
    check("t5_in_wait", busy, 1'b1);
    repeat (5) tick();
    tx_force = 1'b1;
    tick();
    tx_force = 1'b0;
    check("t5_wait_busy", busy,   1'b1);
    check("t5_wait_err",  err,    1'b0);
    check("t5_wait_rdy",  tx_rdy, 1'b0);
    n = 0;
    do begin tick(); n++; end while (busy && n < 200);
    check("t5_wait_rest", n, 40);

    // Asynchronous reset in the middle of WAIT
    do_reset();
    data       = 32'h77C35A11;
    req        = 4'b0100;
    wait_ack(n);
    req = 4'b0000;
    check("t6_grant_id", grant_id, 2'd2);
    repeat (10) tick();
    check("t6_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ack",      ack,      4'b0000);
    check("t6_grant_id0", grant_id, 2'd0);
    check("t6_busy",     busy,     1'b0);
    check("t6_err",      err,      1'b0);
    check("t6_frame",    tx_frame, 10'h3FF);
    check("t6_rdy",      tx_rdy,   1'b0);
    tick();
    rst = 1'b0;
    req = 4'b1010;
    wait_ack(n);
    check("t6_lat",      n,        1);
    check("t6_ack1",     ack,      4'b0010);
    check("t6_grant1",   grant_id, 2'd1);
    check("t6_frame1",   tx_frame, 10'h2B4);
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
